completion_command_queue: RTL and testbench
===========================================

Name: completion_command_queue

Overview:
- Elastic command buffer that sits directly upstream of the completion command channel and drives its Src command interface.
- Accepts commands (opcode, target ID, source ID, address, length) from the host/dispatch side through a valid/ready handshake.
- Stores them in order in a small circular FIFO.
- Presents the head entry to the completion command channel, so that upstream producers are decoupled from that channel's Idle/Report/Forward occupancy.

Parameters:
- AddressWidth, 32, width of the address field.
- InnerIFLengthWidth, 16, width of the length field.
- QueueDepthWidth, 2, log2 of the entry count (depth = 2**QueueDepthWidth = 4 by default); legal values 1..5.

Ports:
- iClock  in  1  single clock, rising edge.
- iReset  in  1  reset, asynchronous, active-low: asserting it clears the queue immediately; it is released synchronously to iClock.
- iCmdOpcode  in  6  command opcode.
- iCmdTargetID  in  5  target ID.
- iCmdSourceID  in  5  source ID.
- iCmdAddress  in  AddressWidth  address.
- iCmdLength  in  InnerIFLengthWidth  length.
- iCmdValid  in  1  upstream command valid.
- oCmdReady  out  1  queue can accept a command.
- oDstOpcode  out  6  head-entry opcode.
- oDstTargetID  out  5  head-entry target ID.
- oDstSourceID  out  5  head-entry source ID.
- oDstAddress  out  AddressWidth  head-entry address.
- oDstLength  out  InnerIFLengthWidth  head-entry length.
- oDstCmdValid  out  1  head entry valid.
- iDstCmdReady  in  1  downstream accepts the head entry.

Behaviour:
- Storage: 2**QueueDepthWidth entries of {opcode, targetID, sourceID, address, length}.
- Pointers: write pointer and read pointer, each QueueDepthWidth+1 bits; the extra MSB distinguishes full from empty.
- Empty: pointers equal. Full: MSBs differ and the lower bits are equal.
- Push: iCmdValid && oCmdReady at a rising edge. Writes the entry at wptr and increments wptr.
- Pop: oDstCmdValid && iDstCmdReady at a rising edge. Increments rptr.
- oCmdReady = !full, decoded from the registered pointers. No combinational path from iDstCmdReady to oCmdReady.
- A push while full is refused, even if a pop happens in the same cycle.
- oDstCmdValid = !empty, from the registered pointers.
- oDst* are the head entry, read combinationally from storage at rptr[QueueDepthWidth-1:0]. Their values are don't-care while oDstCmdValid is low.
- Latency: a command pushed at edge N is visible on oDst* with oDstCmdValid high after edge N (i.e. in cycle N+1). There is no same-cycle bypass.
- Simultaneous push and pop when neither full nor empty: both happen, occupancy is unchanged and order is preserved.
- Simultaneous push and pop when empty: only the push happens, because oDstCmdValid is low.
- Pointer wrap-around: pointers wrap naturally modulo 2**(QueueDepthWidth+1). Ordering is preserved across the wrap.
- Content: the queue neither inspects nor modifies fields. Zero-length and ThisID-targeted commands are enqueued unchanged; the downstream channel decides what to do with them.
- Reset, asserted at any time including mid-transfer:
  - wptr = rptr = 0, so the queue is empty.
  - oDstCmdValid = 0 and oCmdReady = 0 while reset is asserted.
  - oCmdReady = 1 from the first cycle after release.
  - Storage contents are not reset; oDst* show whatever entry 0 holds, which is don't-care because valid is low.
- Handshake rules for the verifier:
  - Once oDstCmdValid rises, it and oDst* stay stable until a pop occurs (AXI-style).
  - The queue never withdraws valid.

Optional Feature:
- Macro: COMPLETION_CMD_QUEUE_LEVEL_EN.
- With the macro defined:
  - Extra output oQueueLevel, width QueueDepthWidth+1 = wptr - rptr (occupancy 0..depth).
  - Extra output oQueueAlmostFull, 1 bit, high when occupancy >= depth-1.
  - Both are combinational from the registered pointers, and both are 0 during reset.
- Without the macro: neither port exists. Core behaviour is identical either way.

Decomposition:
- Shared package (completion_cmd_pkg):
  - Field widths: opcode 6, ID 5.
  - Packed command struct typedef {opcode, targetID, sourceID, address, length}.
  - A localparam for the command bit-width derived from AddressWidth/InnerIFLengthWidth.
- One natural sub-module: completion_cmd_queue_mem.
  - Register-array storage, 1 write port, 1 asynchronous read port, no reset.
- Pointer and flag logic lives in the top module.

Test Plan:
- Reset: hold iReset=0 for 3 cycles, then release -> during reset oCmdReady=0 and oDstCmdValid=0; after release oCmdReady=1 and oDstCmdValid=0.
- Single command: push {opcode=6'h02, target=5'd3, source=5'd1, address=32'h0000_1000, length=16'd8} with iDstCmdReady=0 -> next cycle oDstCmdValid=1 and oDst* match; values hold stable for 5 cycles; raising iDstCmdReady for one cycle pops it and oDstCmdValid falls.
- Fill: push addresses 0x10,0x20,0x30,0x40 with iDstCmdReady=0 -> oCmdReady=0 after the 4th push; a 5th push attempt with 0x50 and concurrent iDstCmdReady=1 pops 0x10 and does not enqueue 0x50; oCmdReady=1 next cycle.
- Streaming and wrap: with iCmdValid=1 and iDstCmdReady=1 continuously, push addresses 0..19 -> all 20 emerge in order, one per cycle after the first-cycle latency, with no drops or duplicates across pointer wrap.
- Reset mid-operation: with 3 entries queued, pull iReset low asynchronously mid-cycle -> oDstCmdValid goes 0 without waiting for a clock edge; after release the queue is empty and the next pushed command is the first one delivered.
- With COMPLETION_CMD_QUEUE_LEVEL_EN: during the fill scenario, oQueueLevel steps 1,2,3,4 and oQueueAlmostFull asserts when the level reaches 3.

Source files
------------

// File: rtl/completion_command_queue_pkg.sv
// Shared command field widths and payload layout for the completion command queue.
package completion_cmd_pkg;

  localparam int unsigned OpcodeWidth        = 6;
  localparam int unsigned IdWidth            = 5;
  localparam int unsigned DefaultAddressWidth = 32;
  localparam int unsigned DefaultLengthWidth  = 16;

  // Flattened command width for a given address/length configuration
  function automatic int unsigned cmdWidth(input int unsigned addressWidth,
                                           input int unsigned lengthWidth);
    return OpcodeWidth + 2 * IdWidth + addressWidth + lengthWidth;
  endfunction

  localparam int unsigned DefaultCmdWidth = cmdWidth(DefaultAddressWidth, DefaultLengthWidth);

  typedef struct packed {
    logic [OpcodeWidth-1:0]         opcode;
    logic [IdWidth-1:0]             targetID;
    logic [IdWidth-1:0]             sourceID;
    logic [DefaultAddressWidth-1:0] address;
    logic [DefaultLengthWidth-1:0]  length;
  } completionCmd_t;

endpackage

// File: rtl/completion_command_queue_mem.sv
// Register-array command storage: one write port, one asynchronous read port, no reset.
module completion_cmd_queue_mem #(
  parameter int unsigned DepthWidth = 2,
  parameter int unsigned DataWidth  = 64
) (
  input  logic                  iClock,
  input  logic                  iWriteEnable,
  input  logic [DepthWidth-1:0] iWriteAddr,
  input  logic [DataWidth-1:0]  iWriteData,
  input  logic [DepthWidth-1:0] iReadAddr,
  output logic [DataWidth-1:0]  oReadData
);

  localparam int unsigned Depth = 1 << DepthWidth;

  logic [DataWidth-1:0] entries [Depth];

  always_ff @(posedge iClock) begin
    if (iWriteEnable) begin
      entries[iWriteAddr] <= iWriteData;
    end
  end

  assign oReadData = entries[iReadAddr];

endmodule

// File: rtl/completion_command_queue.sv
// Elastic in-order command FIFO feeding the completion command channel.
// Optional occupancy outputs oQueueLevel/oQueueAlmostFull under COMPLETION_CMD_QUEUE_LEVEL_EN.
module completion_command_queue
  import completion_cmd_pkg::*;
#(
  parameter int unsigned AddressWidth       = 32,
  parameter int unsigned InnerIFLengthWidth = 16,
  parameter int unsigned QueueDepthWidth    = 2
) (
  input  logic                          iClock,
  input  logic                          iReset,
  input  logic [OpcodeWidth-1:0]        iCmdOpcode,
  input  logic [IdWidth-1:0]            iCmdTargetID,
  input  logic [IdWidth-1:0]            iCmdSourceID,
  input  logic [AddressWidth-1:0]       iCmdAddress,
  input  logic [InnerIFLengthWidth-1:0] iCmdLength,
  input  logic                          iCmdValid,
  output logic                          oCmdReady,
  output logic [OpcodeWidth-1:0]        oDstOpcode,
  output logic [IdWidth-1:0]            oDstTargetID,
  output logic [IdWidth-1:0]            oDstSourceID,
  output logic [AddressWidth-1:0]       oDstAddress,
  output logic [InnerIFLengthWidth-1:0] oDstLength,
  output logic                          oDstCmdValid,
  input  logic                          iDstCmdReady
`ifdef COMPLETION_CMD_QUEUE_LEVEL_EN
  ,
  output logic [QueueDepthWidth:0]      oQueueLevel,
  output logic                          oQueueAlmostFull
`endif
);

  localparam int unsigned PtrWidth = QueueDepthWidth + 1;
  localparam int unsigned Depth    = 1 << QueueDepthWidth;
  localparam int unsigned CmdWidth = cmdWidth(AddressWidth, InnerIFLengthWidth);

  logic [PtrWidth-1:0] wrPtr;
  logic [PtrWidth-1:0] rdPtr;
  logic                readyEn;
  logic                empty;
  logic                full;
  logic                push;
  logic                pop;
  logic [CmdWidth-1:0] wrData;
  logic [CmdWidth-1:0] rdData;

  // Extra pointer MSB separates the full and empty cases
  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[QueueDepthWidth] != rdPtr[QueueDepthWidth]) &&
                 (wrPtr[QueueDepthWidth-1:0] == rdPtr[QueueDepthWidth-1:0]);

  // readyEn keeps oCmdReady low while reset is held, independent of pointer state
  assign oCmdReady    = readyEn && !full;
  assign oDstCmdValid = !empty;
  assign push         = iCmdValid && oCmdReady;
  assign pop          = oDstCmdValid && iDstCmdReady;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      readyEn <= 1'b0;
    end else begin
      readyEn <= 1'b1;
      if (push) begin
        wrPtr <= wrPtr + PtrWidth'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrWidth'(1);
      end
    end
  end

  assign wrData = {iCmdOpcode, iCmdTargetID, iCmdSourceID, iCmdAddress, iCmdLength};

  completion_cmd_queue_mem #(
    .DepthWidth (QueueDepthWidth),
    .DataWidth  (CmdWidth)
  ) uMem (
    .iClock       (iClock),
    .iWriteEnable (push),
    .iWriteAddr   (wrPtr[QueueDepthWidth-1:0]),
    .iWriteData   (wrData),
    .iReadAddr    (rdPtr[QueueDepthWidth-1:0]),
    .oReadData    (rdData)
  );

  assign {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength} = rdData;

`ifdef COMPLETION_CMD_QUEUE_LEVEL_EN
  assign oQueueLevel      = wrPtr - rdPtr;
  assign oQueueAlmostFull = (oQueueLevel >= PtrWidth'(Depth - 1));
`endif

endmodule

// File: tb/tb_completion_command_queue.sv
// Scoreboard bench for completion_command_queue (default parameters).
// Also checks oQueueLevel/oQueueAlmostFull when COMPLETION_CMD_QUEUE_LEVEL_EN is defined.
module tb_completion_command_queue;
  import completion_cmd_pkg::*;

  localparam int Depth = 4;

  logic        iClock = 1'b0;
  logic        iReset;
  logic [5:0]  iCmdOpcode;
  logic [4:0]  iCmdTargetID;
  logic [4:0]  iCmdSourceID;
  logic [31:0] iCmdAddress;
  logic [15:0] iCmdLength;
  logic        iCmdValid;
  logic        oCmdReady;
  logic [5:0]  oDstOpcode;
  logic [4:0]  oDstTargetID;
  logic [4:0]  oDstSourceID;
  logic [31:0] oDstAddress;
  logic [15:0] oDstLength;
  logic        oDstCmdValid;
  logic        iDstCmdReady;
`ifdef COMPLETION_CMD_QUEUE_LEVEL_EN
  logic [2:0]  oQueueLevel;
  logic        oQueueAlmostFull;
`endif

  completion_command_queue dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iCmdOpcode   (iCmdOpcode),
    .iCmdTargetID (iCmdTargetID),
    .iCmdSourceID (iCmdSourceID),
    .iCmdAddress  (iCmdAddress),
    .iCmdLength   (iCmdLength),
    .iCmdValid    (iCmdValid),
    .oCmdReady    (oCmdReady),
    .oDstOpcode   (oDstOpcode),
    .oDstTargetID (oDstTargetID),
    .oDstSourceID (oDstSourceID),
    .oDstAddress  (oDstAddress),
    .oDstLength   (oDstLength),
    .oDstCmdValid (oDstCmdValid),
    .iDstCmdReady (iDstCmdReady)
`ifdef COMPLETION_CMD_QUEUE_LEVEL_EN
    ,
    .oQueueLevel      (oQueueLevel),
    .oQueueAlmostFull (oQueueAlmostFull)
`endif
  );

  always #5 iClock = ~iClock;

  completionCmd_t expQ[$];
  int  assertCount = 0;
  int  failCount   = 0;
  int  popCount    = 0;
  bit  rstDone     = 1'b0;

  task automatic checkValue(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  function automatic completionCmd_t mkCmd(input logic [5:0] op, input logic [4:0] tgt,
                                           input logic [4:0] src, input logic [31:0] addr,
                                           input logic [15:0] len);
    completionCmd_t c;
    c.opcode   = op;
    c.targetID = tgt;
    c.sourceID = src;
    c.address  = addr;
    c.length   = len;
    return c;
  endfunction

  // One clock: drive at negedge, check against model, advance model at posedge
  task automatic cycle(input bit valid, input completionCmd_t cmd, input bit dstReady);
    completionCmd_t head;
    bit canPush;
    bit doPop;
    iCmdValid    = valid;
    iCmdOpcode   = cmd.opcode;
    iCmdTargetID = cmd.targetID;
    iCmdSourceID = cmd.sourceID;
    iCmdAddress  = cmd.address;
    iCmdLength   = cmd.length;
    iDstCmdReady = dstReady;
    #1;
    checkValue("cmdReady", 64'(oCmdReady), 64'(rstDone && (expQ.size() < Depth)));
    checkValue("dstValid", 64'(oDstCmdValid), 64'(expQ.size() > 0));
`ifdef COMPLETION_CMD_QUEUE_LEVEL_EN
    checkValue("queueLevel", 64'(oQueueLevel), 64'(expQ.size()));
    checkValue("almostFull", 64'(oQueueAlmostFull), 64'(expQ.size() >= Depth - 1));
`endif
    if (expQ.size() > 0) begin
      head = expQ[0];
      checkValue("dstCmd", {oDstOpcode, oDstTargetID, oDstSourceID, oDstAddress, oDstLength}, head);
    end
    canPush = iReset && rstDone && valid && (expQ.size() < Depth);
    doPop   = iReset && dstReady && (expQ.size() > 0);
    @(posedge iClock);
    if (doPop) begin
      void'(expQ.pop_front());
      popCount++;
    end
    if (canPush) expQ.push_back(cmd);
    rstDone = iReset;
    @(negedge iClock);
  endtask

  task automatic drain(input int budget);
    completionCmd_t idle;
    idle = mkCmd(6'h0, 5'h0, 5'h0, 32'h0, 16'h0);
    for (int i = 0; i < budget && expQ.size() > 0; i++) cycle(1'b0, idle, 1'b1);
    checkValue("drainTimeout", 64'(expQ.size()), 64'd0);
  endtask

  initial begin
    completionCmd_t idle;
    int startPops;
    idle = mkCmd(6'h0, 5'h0, 5'h0, 32'h0, 16'h0);
    iReset = 1'b0;
    iCmdValid = 1'b0;
    iDstCmdReady = 1'b0;
    iCmdOpcode = '0; iCmdTargetID = '0; iCmdSourceID = '0; iCmdAddress = '0; iCmdLength = '0;
    @(negedge iClock);

    // Reset held for three cycles, then released
    repeat (3) cycle(1'b0, idle, 1'b0);
    iReset = 1'b1;
    cycle(1'b0, idle, 1'b0);
    cycle(1'b0, idle, 1'b0);

    // Single command held stable while downstream stalls, then popped
    cycle(1'b1, mkCmd(6'h02, 5'd3, 5'd1, 32'h0000_1000, 16'd8), 1'b0);
    repeat (5) cycle(1'b0, idle, 1'b0);
    cycle(1'b0, idle, 1'b1);
    cycle(1'b0, idle, 1'b0);

    // Fill to capacity; push while full with concurrent pop must be refused
    for (int i = 1; i <= 4; i++) cycle(1'b1, mkCmd(6'h05, 5'd2, 5'd7, 32'(i * 16), 16'd4), 1'b0);
    cycle(1'b1, mkCmd(6'h05, 5'd2, 5'd7, 32'h50, 16'd4), 1'b1);
    cycle(1'b0, idle, 1'b0);
    drain(10);

    // Continuous streaming across pointer wrap, including a zero-length command
    startPops = popCount;
    for (int i = 0; i < 20; i++)
      cycle(1'b1, mkCmd(6'(i + 1), 5'(i), 5'(31 - i), 32'(i), (i == 7) ? 16'd0 : 16'(i * 3)), 1'b1);
    drain(10);
    checkValue("streamCount", 64'(popCount - startPops), 64'd20);

    // Asynchronous reset mid-cycle with three entries queued
    for (int i = 0; i < 3; i++) cycle(1'b1, mkCmd(6'h11, 5'd9, 5'd4, 32'hA000 + 32'(i), 16'd2), 1'b0);
    #2;
    iReset = 1'b0;
    #1;
    checkValue("asyncRstValid", 64'(oDstCmdValid), 64'd0);
    checkValue("asyncRstReady", 64'(oCmdReady), 64'd0);
    expQ.delete();
    rstDone = 1'b0;
    @(negedge iClock);
    cycle(1'b0, idle, 1'b0);
    iReset = 1'b1;
    cycle(1'b1, mkCmd(6'h3F, 5'd0, 5'd0, 32'hDEAD_BEEF, 16'd0), 1'b0);
    startPops = popCount;
    cycle(1'b1, mkCmd(6'h21, 5'd12, 5'd13, 32'hCAFE_0001, 16'd16), 1'b0);
    cycle(1'b0, idle, 1'b0);
    drain(10);
    checkValue("postRstCount", 64'(popCount - startPops), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
